// File: rtl/conv_pkg.sv
// Shared instruction encoding: opcode values and the legality test used by
// instruction queues.
package conv_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_LF = 4'h1,
    OP_LS = 4'h2,
    OP_LI = 4'h3,
    OP_DC = 4'h4
  } op_e;

  function automatic logic is_legal_op(op_e op);
    return (op == OP_LF) || (op == OP_LS) || (op == OP_LI) || (op == OP_DC);
  endfunction

endpackage

// File: rtl/inst_queue_mem.sv
// Instruction queue storage: synchronous write, asynchronous read, no reset.
module inst_queue_mem #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue: filters illegal opcodes on write, full-depth circular
// buffer with a level counter, combinational handshakes and head data.
module inst_queue
  import conv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AF_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_inst,
  input  logic                  w_valid,
  output logic                  w_ready,
  output logic                  w_illegal,
  input  logic                  r_en,
  output logic                  r_accept,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic [7:0]            illegal_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LVL_W = ADDR_WIDTH + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(DEPTH - AF_MARGIN);

  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  legal;
  logic                  wr_fire;
  logic                  rd_fire;

  assign legal = is_legal_op(op_e'(in_inst[DATA_WIDTH-1 -: OP_W]));

  assign w_ready     = (level != LVL_FULL);
  assign r_accept    = r_en && (level != '0);
  assign w_illegal   = w_valid && w_ready && !legal;
  assign almost_full = (level >= LVL_AF);

  // Flush overrides any same-cycle transfer for state purposes.
  assign wr_fire = w_valid && w_ready && legal && !flush;
  assign rd_fire = r_accept && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      level <= '0;
    end else if (flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
      level <= '0;
    end else begin
      if (wr_fire) w_ptr <= w_ptr + ADDR_WIDTH'(1);
      if (rd_fire) r_ptr <= r_ptr + ADDR_WIDTH'(1);
      if (wr_fire && !rd_fire)      level <= level + LVL_W'(1);
      else if (!wr_fire && rd_fire) level <= level - LVL_W'(1);
    end
  end

  // Saturating drop counter; survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (w_illegal && !flush && (illegal_cnt != 8'hFF)) begin
      illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

  inst_queue_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_fire),
    .waddr(w_ptr),
    .wdata(in_inst),
    .raddr(r_ptr),
    .rdata(out_inst)
  );

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_inst_queue;
  import conv_pkg::*;

  localparam int DEPTH = 8;
  localparam int AF    = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] in_inst;
  logic        w_valid;
  logic        w_ready;
  logic        w_illegal;
  logic        r_en;
  logic        r_accept;
  logic [31:0] out_inst;
  logic [3:0]  level;
  logic        almost_full;
  logic [7:0]  illegal_cnt;

  inst_queue #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .AF_MARGIN(AF)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_inst(in_inst),
    .w_valid(w_valid), .w_ready(w_ready), .w_illegal(w_illegal),
    .r_en(r_en), .r_accept(r_accept), .out_inst(out_inst),
    .level(level), .almost_full(almost_full), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] sb[$];
  int   mlevel = 0;
  int   mcnt   = 0;
  bit   pending_flush = 0;
  bit   check_en = 0;
  logic exp_w_ready, exp_r_accept, exp_w_illegal, exp_af;
  int   exp_level, exp_cnt;

  logic [3:0] legal_ops [4];
  initial legal_ops = '{4'(OP_LF), 4'(OP_LS), 4'(OP_LI), 4'(OP_DC)};

  function automatic bit legal_op(logic [3:0] op);
    return op inside {OP_LF, OP_LS, OP_LI, OP_DC};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus; expectations are derived from the model's
  // pre-edge occupancy, then the model advances to the post-edge state.
  task automatic cycle(input logic wv, input logic [31:0] d, input logic re, input logic fl);
    bit lg, wr, rd;
    @(posedge clk); #1;
    if (pending_flush) begin sb.delete(); pending_flush = 0; end
    w_valid = wv; in_inst = d; r_en = re; flush = fl;
    lg = legal_op(d[31:28]);
    exp_w_ready   = (mlevel != DEPTH);
    exp_r_accept  = re && (mlevel != 0);
    exp_w_illegal = wv && (mlevel != DEPTH) && !lg;
    exp_af        = (mlevel >= DEPTH - AF);
    exp_level     = mlevel;
    exp_cnt       = mcnt;
    check_en      = 1;
    if (fl) begin
      mlevel = 0;
      pending_flush = 1;
    end else begin
      wr = wv && (mlevel < DEPTH) && lg;
      rd = re && (mlevel > 0);
      if (wr) sb.push_back(d);
      mlevel = mlevel + int'(wr) - int'(rd);
      if (exp_w_illegal && mcnt < 255) mcnt++;
    end
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    sb.delete();
    mlevel = 0;
    mcnt = 0;
    pending_flush = 0;
  endtask

  // Monitor: compare all outputs and pop the scoreboard on accepted reads.
  always @(negedge clk) begin
    if (check_en && rst_n) begin
      check("w_ready", 32'(w_ready), 32'(exp_w_ready));
      check("r_accept", 32'(r_accept), 32'(exp_r_accept));
      check("w_illegal", 32'(w_illegal), 32'(exp_w_illegal));
      check("almost_full", 32'(almost_full), 32'(exp_af));
      check("level", 32'(level), 32'(exp_level));
      check("illegal_cnt", 32'(illegal_cnt), 32'(exp_cnt));
      if (r_accept) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL read_underflow: got read data %0h expected no read at %0t", out_inst, $time);
        end else begin
          check("out_inst", out_inst, sb.pop_front());
        end
      end
    end
  end

  logic [31:0] d;
  int ph;

  initial begin
    rst_n = 1'b0; flush = 0; w_valid = 0; r_en = 1; in_inst = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_level", 32'(level), 32'd0);
    check("rst_w_ready", 32'(w_ready), 32'd1);
    check("rst_r_accept", 32'(r_accept), 32'd0);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_cnt", 32'(illegal_cnt), 32'd0);
    r_en = 0;
    @(negedge clk); rst_n = 1'b1;

    // Fill and drain.
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
    idle();
    cycle(1'b1, 32'h1000_00FF, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    idle();

    // Illegal opcode drop and saturation.
    for (int i = 0; i < 300; i++) cycle(1'b1, 32'hF000_0000 + 32'(i), 1'b0, 1'b0);
    idle();

    // Simultaneous read/write at full and at empty.
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h2000_00AA, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 7; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h3000_0055, 1'b1, 1'b0);
    idle();
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    idle();

    // Pointer wrap at constant level 3.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h4000_0000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h4100_0000 + 32'(i), 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    idle();

    // Flush with a same-cycle legal write.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h1500_0000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h1500_00EE, 1'b0, 1'b1);
    idle();
    cycle(1'b1, 32'h1600_0001, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    idle();

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h1700_0000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'hE000_0000, 1'b0, 1'b0);
    @(posedge clk); #3;
    check_en = 0; w_valid = 0; flush = 0; r_en = 1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_w_ready", 32'(w_ready), 32'd1);
    check("mid_rst_r_accept", 32'(r_accept), 32'd0);
    check("mid_rst_cnt", 32'(illegal_cnt), 32'd0);
    r_en = 0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    idle();

    // Random traffic with phases biased toward filling or draining.
    for (int i = 0; i < 3000; i++) begin
      bit wv, re, fl;
      ph = (i / 150) % 3;
      fl = ($urandom_range(0, 99) < 2);
      wv = !fl && ($urandom_range(0, 99) < (ph == 0 ? 80 : (ph == 1 ? 30 : 55)));
      re = ($urandom_range(0, 99) < (ph == 0 ? 30 : (ph == 1 ? 80 : 55)));
      d = $urandom();
      if ($urandom_range(0, 99) < 75) d[31:28] = legal_ops[$urandom_range(0, 3)];
      cycle(wv, d, re, fl);
    end
    idle();
    @(negedge clk); #1;
    check_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
